// File: rtl/gnr_attractor_ctrl_pkg.sv
// Shared types and defaults for the gene-regulatory-network attractor sequencer.
package gnr_attractor_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_PERIOD = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int          CNT_W_DEF     = 16;
  localparam logic [15:0] MAX_STEPS_DEF = 16'hFFFF;

  // A meet is only legal on an even, nonzero step count.
  function automatic logic even_nonzero(input logic [CNT_W_DEF-1:0] cnt);
    return (cnt != '0) && !cnt[0];
  endfunction

endpackage

// File: rtl/gnr_vec_cmp.sv
// Equality comparator between the slow and fast trajectory state vectors.
module gnr_vec_cmp #(
  parameter int N_NODES = 8
) (
  input  logic [N_NODES-1:0] a_vec,
  input  logic [N_NODES-1:0] b_vec,
  output logic               eq
);

  assign eq = (a_vec == b_vec);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Floyd tortoise/hare sequencer: loads the node cells, searches for a meet,
// then freezes the slow copy and steps the fast copy to measure the period.
module gnr_attractor_ctrl
  import gnr_attractor_ctrl_pkg::*;
#(
  parameter int               N_NODES   = 8,
  parameter int               CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MAX_STEPS = CNT_W'(MAX_STEPS_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   meet_steps,
  output logic [CNT_W-1:0]   period,
  output logic [2:0]         dbg_state,
  output logic [CNT_W-1:0]   dbg_step_cnt
);

  state_e             state_q, state_d;
  logic               reset_nos_q, reset_nos_d;
  logic               start_s0_q, start_s0_d;
  logic               start_s1_q, start_s1_d;
  logic [N_NODES-1:0] init_state_q, init_state_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   meet_steps_q, meet_steps_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]   step_inc, per_inc;
  logic               vec_eq;
  logic               step_even_nz;

  gnr_vec_cmp #(.N_NODES(N_NODES)) u_cmp (
    .a_vec (s0_vec),
    .b_vec (s1_vec),
    .eq    (vec_eq)
  );

  assign step_inc     = (step_cnt_q == MAX_STEPS) ? step_cnt_q : step_cnt_q + CNT_W'(1);
  assign per_inc      = (per_cnt_q == MAX_STEPS) ? per_cnt_q : per_cnt_q + CNT_W'(1);
  assign step_even_nz = (step_cnt_q != '0) && !step_cnt_q[0];

  // Strobes are registered: a strobe high during a cycle is consumed by the
  // node cells at the closing clock edge, so a cycle with a strobe in flight
  // only counts it, and s0/s1 are compared in the following strobe-free cycle.
  always_comb begin
    state_d      = state_q;
    reset_nos_d  = 1'b0;
    start_s0_d   = 1'b0;
    start_s1_d   = 1'b0;
    init_state_d = init_state_q;
    timeout_d    = timeout_q;
    meet_steps_d = meet_steps_q;
    period_d     = period_q;
    step_cnt_d   = step_cnt_q;
    per_cnt_d    = per_cnt_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            init_state_d = init_vec;
            step_cnt_d   = '0;
            per_cnt_d    = '0;
            timeout_d    = 1'b0;
            meet_steps_d = '0;
            period_d     = '0;
            reset_nos_d  = 1'b1;
            state_d      = ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Step 0 can never meet, so the first step is issued straight away.
          state_d    = ST_SEARCH;
          step_cnt_d = '0;
          if (MAX_STEPS != '0) begin
            start_s0_d = 1'b1;
            start_s1_d = 1'b1;
          end
        end
        ST_SEARCH: begin
          if (start_s1_q) begin
            step_cnt_d = step_inc;
            if (step_inc[0] && (step_inc != MAX_STEPS)) begin
              start_s0_d = 1'b1;
              start_s1_d = 1'b1;
            end
          end else if (step_even_nz && vec_eq) begin
            meet_steps_d = step_cnt_q;
            per_cnt_d    = '0;
            state_d      = ST_PERIOD;
            if (MAX_STEPS != '0) start_s1_d = 1'b1;
          end else if (step_cnt_q == MAX_STEPS) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            start_s0_d = 1'b1;
            start_s1_d = 1'b1;
          end
        end
        ST_PERIOD: begin
          if (start_s1_q) begin
            per_cnt_d = per_inc;
          end else if ((per_cnt_q != '0) && vec_eq) begin
            period_d = per_cnt_q;
            state_d  = ST_DONE;
          end else if (per_cnt_q == MAX_STEPS) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            start_s1_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      reset_nos_q  <= 1'b0;
      start_s0_q   <= 1'b0;
      start_s1_q   <= 1'b0;
      init_state_q <= '0;
      timeout_q    <= 1'b0;
      meet_steps_q <= '0;
      period_q     <= '0;
      step_cnt_q   <= '0;
      per_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      reset_nos_q  <= reset_nos_d;
      start_s0_q   <= start_s0_d;
      start_s1_q   <= start_s1_d;
      init_state_q <= init_state_d;
      timeout_q    <= timeout_d;
      meet_steps_q <= meet_steps_d;
      period_q     <= period_d;
      step_cnt_q   <= step_cnt_d;
      per_cnt_q    <= per_cnt_d;
    end
  end

  assign reset_nos    = reset_nos_q;
  assign start_s0     = start_s0_q;
  assign start_s1     = start_s1_q;
  assign init_state   = init_state_q;
  assign timeout      = timeout_q;
  assign meet_steps   = meet_steps_q;
  assign period       = period_q;
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_SEARCH) || (state_q == ST_PERIOD);
  assign done         = (state_q == ST_DONE);
  assign dbg_state    = state_q;
  assign dbg_step_cnt = step_cnt_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with a behavioural model of the
// dual-trajectory node cells for several small networks.
module tb_gnr_attractor_ctrl;
  import gnr_attractor_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  init_vec;
  logic [7:0]  s0_vec = '0;
  logic [7:0]  s1_vec = '0;
  logic        reset_nos;
  logic [7:0]  init_state;
  logic        start_s0;
  logic        start_s1;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] meet_steps;
  logic [15:0] period;
  logic [2:0]  dbg_state;
  logic [15:0] dbg_step_cnt;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   net_sel = 0;
  logic s0_ph = 1'b0;
  int   rn_cnt = 0;
  int   s1_cnt = 0;
  int   s0_per_cnt = 0;

  always #5 clk = ~clk;

  gnr_attractor_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_STEPS(16'd20)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .init_vec     (init_vec),
    .s0_vec       (s0_vec),
    .s1_vec       (s1_vec),
    .reset_nos    (reset_nos),
    .init_state   (init_state),
    .start_s0     (start_s0),
    .start_s1     (start_s1),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .meet_steps   (meet_steps),
    .period       (period),
    .dbg_state    (dbg_state),
    .dbg_step_cnt (dbg_step_cnt)
  );

  // 0: identity, 1: toggle, 2: 3-bit rotate-left, 3: increment
  function automatic logic [7:0] f_net(input logic [7:0] x);
    case (net_sel)
      0:       return x;
      1:       return ~x;
      2:       return {x[7:3], x[1:0], x[2]};
      default: return x + 8'd1;
    endcase
  endfunction

  // Node cells: s1 steps on every start_s1, s0 on every second start_s0.
  always @(posedge clk) begin
    if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      s0_ph  <= 1'b0;
    end else begin
      if (start_s1) s1_vec <= f_net(s1_vec);
      if (start_s0) begin
        s0_ph <= ~s0_ph;
        if (s0_ph) s0_vec <= f_net(s0_vec);
      end
    end
    if (reset_nos) rn_cnt <= rn_cnt + 1;
    if (start_s1) s1_cnt <= s1_cnt + 1;
    if (start_s0 && (dbg_state == ST_PERIOD)) s0_per_cnt <= s0_per_cnt + 1;
  end

  task automatic launch(input logic [7:0] iv, output int cyc, output bit ok);
    @(negedge clk);
    init_vec = iv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; init_vec = '0;
    #1 rst = 1'b0;
    #1;
    vec_cnt++;
    if ({busy, done, timeout, reset_nos, start_s0, start_s1} !== 6'b0) begin
      err_cnt++; $display("FAIL reset_flags: got %b expected 000000", {busy, done, timeout, reset_nos, start_s0, start_s1});
    end
    vec_cnt++;
    if ({init_state, meet_steps, period} !== 40'h0) begin
      err_cnt++; $display("FAIL reset_data: got %h expected 0", {init_state, meet_steps, period});
    end
    vec_cnt++;
    if (dbg_state !== 3'd0) begin
      err_cnt++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({busy, done, dbg_state} !== 5'b0) begin
      err_cnt++; $display("FAIL reset_idle: got %b expected 00000", {busy, done, dbg_state});
    end
  endtask

  task automatic test_identity();
    int cyc; bit ok; int rn0;
    net_sel = 0; rn0 = rn_cnt;
    launch(8'hA5, cyc, ok);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL identity_done: got done=0 expected 1 within budget"); end
    vec_cnt++;
    if (cyc != 6) begin err_cnt++; $display("FAIL identity_latency: got %0d expected 6", cyc); end
    vec_cnt++;
    if (meet_steps !== 16'd2 || period !== 16'd1 || timeout !== 1'b0) begin
      err_cnt++; $display("FAIL identity_result: got meet=%0d per=%0d to=%b expected 2 1 0", meet_steps, period, timeout);
    end
    vec_cnt++;
    if (rn_cnt - rn0 != 1) begin err_cnt++; $display("FAIL identity_reset_nos: got %0d pulses expected 1", rn_cnt - rn0); end
    vec_cnt++;
    if (init_state !== 8'hA5) begin err_cnt++; $display("FAIL identity_init: got %h expected a5", init_state); end
  endtask

  task automatic test_toggle();
    int cyc; bit ok;
    net_sel = 1;
    launch(8'h0F, cyc, ok);
    vec_cnt++;
    if (!ok || cyc != 11) begin err_cnt++; $display("FAIL toggle_latency: got done=%b cyc=%0d expected 1 11", ok, cyc); end
    vec_cnt++;
    if (meet_steps !== 16'd4 || period !== 16'd2 || timeout !== 1'b0) begin
      err_cnt++; $display("FAIL toggle_result: got meet=%0d per=%0d to=%b expected 4 2 0", meet_steps, period, timeout);
    end
  endtask

  task automatic test_rotate();
    int cyc; bit ok; int sp0;
    net_sel = 2; sp0 = s0_per_cnt;
    launch(8'h01, cyc, ok);
    vec_cnt++;
    if (!ok || cyc != 16) begin err_cnt++; $display("FAIL rotate_latency: got done=%b cyc=%0d expected 1 16", ok, cyc); end
    vec_cnt++;
    if (meet_steps !== 16'd6 || period !== 16'd3 || timeout !== 1'b0) begin
      err_cnt++; $display("FAIL rotate_result: got meet=%0d per=%0d to=%b expected 6 3 0", meet_steps, period, timeout);
    end
    vec_cnt++;
    if (s0_per_cnt != sp0) begin err_cnt++; $display("FAIL rotate_s0_frozen: got %0d start_s0 in PERIOD expected 0", s0_per_cnt - sp0); end
  endtask

  task automatic test_timeout();
    int cyc; bit ok; int s10;
    net_sel = 3; s10 = s1_cnt;
    launch(8'h00, cyc, ok);
    vec_cnt++;
    if (!ok || cyc != 31) begin err_cnt++; $display("FAIL timeout_latency: got done=%b cyc=%0d expected 1 31", ok, cyc); end
    vec_cnt++;
    if (timeout !== 1'b1 || meet_steps !== 16'd0 || period !== 16'd0) begin
      err_cnt++; $display("FAIL timeout_result: got to=%b meet=%0d per=%0d expected 1 0 0", timeout, meet_steps, period);
    end
    vec_cnt++;
    if (s1_cnt - s10 != 20) begin err_cnt++; $display("FAIL timeout_pulses: got %0d expected 20", s1_cnt - s10); end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (dbg_step_cnt !== 16'd20 || done !== 1'b1) begin
      err_cnt++; $display("FAIL timeout_hold: got step=%0d done=%b expected 20 1", dbg_step_cnt, done);
    end
  endtask

  task automatic test_abort();
    int cyc; bit ok; int n; int rn0;
    net_sel = 2;
    @(negedge clk);
    init_vec = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dbg_state != ST_SEARCH && n < 20) begin @(negedge clk); n++; end
    vec_cnt++;
    if (dbg_state != ST_SEARCH) begin err_cnt++; $display("FAIL abort_reach_search: got %0d expected 2", dbg_state); end
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vec_cnt++;
    if ({dbg_state, busy, done, reset_nos, start_s0, start_s1} !== 8'b0) begin
      err_cnt++; $display("FAIL abort_idle: got %b expected 00000000", {dbg_state, busy, done, reset_nos, start_s0, start_s1});
    end
    vec_cnt++;
    if (meet_steps !== 16'd0 || period !== 16'd0) begin
      err_cnt++; $display("FAIL abort_results: got meet=%0d per=%0d expected 0 0", meet_steps, period);
    end
    rn0 = rn_cnt;
    launch(8'h01, cyc, ok);
    vec_cnt++;
    if (!ok || meet_steps !== 16'd6 || period !== 16'd3 || rn_cnt - rn0 != 1) begin
      err_cnt++; $display("FAIL abort_restart: got done=%b meet=%0d per=%0d rn=%0d expected 1 6 3 1", ok, meet_steps, period, rn_cnt - rn0);
    end
  endtask

  task automatic test_busy_start_and_rst();
    int n; int rn0;
    net_sel = 1; rn0 = rn_cnt;
    @(negedge clk);
    init_vec = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dbg_state != ST_SEARCH && n < 20) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (rn_cnt - rn0 != 1 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL busy_start_ignored: got rn=%0d busy=%b expected 1 1", rn_cnt - rn0, busy);
    end
    n = 0;
    while (dbg_state != ST_PERIOD && n < 40) begin @(negedge clk); n++; end
    vec_cnt++;
    if (dbg_state != ST_PERIOD) begin err_cnt++; $display("FAIL rst_reach_period: got %0d expected 3", dbg_state); end
    #2 rst = 1'b0;
    #1;
    vec_cnt++;
    if ({dbg_state, busy, done, timeout, reset_nos, start_s0, start_s1} !== 9'b0) begin
      err_cnt++; $display("FAIL rst_flags: got %b expected 000000000", {dbg_state, busy, done, timeout, reset_nos, start_s0, start_s1});
    end
    vec_cnt++;
    if ({init_state, meet_steps, period} !== 40'h0) begin
      err_cnt++; $display("FAIL rst_data: got %h expected 0", {init_state, meet_steps, period});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (dbg_state !== 3'd0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL rst_release: got state=%0d busy=%b expected 0 0", dbg_state, busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit ok; int rn0;
    net_sel = 0;
    launch(8'h5A, cyc, ok);
    vec_cnt++;
    if (!ok || meet_steps !== 16'd2 || period !== 16'd1) begin
      err_cnt++; $display("FAIL b2b_first: got done=%b meet=%0d per=%0d expected 1 2 1", ok, meet_steps, period);
    end
    net_sel = 1; rn0 = rn_cnt;
    launch(8'hC3, cyc, ok);
    vec_cnt++;
    if (!ok || cyc != 11 || meet_steps !== 16'd4 || period !== 16'd2) begin
      err_cnt++; $display("FAIL b2b_restart: got done=%b cyc=%0d meet=%0d per=%0d expected 1 11 4 2", ok, cyc, meet_steps, period);
    end
    vec_cnt++;
    if (rn_cnt - rn0 != 1 || init_state !== 8'hC3) begin
      err_cnt++; $display("FAIL b2b_reload: got rn=%0d init=%h expected 1 c3", rn_cnt - rn0, init_state);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_toggle();
    test_rotate();
    test_timeout();
    test_abort();
    test_busy_start_and_rst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
